// File: rtl/riscv_run_controller_if.sv
// riscv_run_controller_if: core register-file write port observed by the run controller
interface riscv_run_controller_if;
  logic        reg_wr_valid;
  logic [4:0]  reg_writeaddr;
  logic [31:0] reg_writedata;
  modport master (output reg_wr_valid, reg_writeaddr, reg_writedata);
  modport slave (input reg_wr_valid, reg_writeaddr, reg_writedata);
endinterface

// File: rtl/riscv_run_controller.sv
// riscv_run_controller: reset-hold, run, halt-marker and timeout sequencer for the core
module riscv_run_controller #(
  parameter int          RESET_CYCLES = 4,
  parameter logic [4:0]  HALT_REG     = 5'd12,
  parameter logic [31:0] HALT_VALUE   = 32'd1,
  parameter logic [4:0]  RESULT_REG   = 5'd10,
  parameter int          TIMEOUT_W    = 20
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  riscv_run_controller_if.slave  wr,
  output logic                   core_reset,
  output logic                   imem_read_en,
  output logic                   busy,
  output logic                   done,
  output logic                   timed_out,
  output logic [TIMEOUT_W-1:0]   cycle_count,
  output logic [15:0]            write_count,
  output logic [31:0]            result
);
  typedef enum logic [2:0] {IDLE, RESET_HOLD, RUN, HALTED, TIMEOUT} state_e;
  localparam logic [7:0] HOLD_INIT = 8'(RESET_CYCLES - 1);
  state_e               state_q, state_d;
  logic [7:0]           hold_q, hold_d;
  logic [TIMEOUT_W-1:0] cycle_count_q, cycle_count_d;
  logic [15:0]          write_count_q, write_count_d;
  logic [31:0]          result_q, result_d;
  logic                 core_reset_q, imem_read_en_q, busy_q, done_q, timed_out_q;
  logic                 wr_ok, halt;
  assign wr_ok = state_q == RUN && wr.reg_wr_valid && wr.reg_writeaddr != 5'd0;
  assign halt  = wr_ok && wr.reg_writeaddr == HALT_REG && wr.reg_writedata == HALT_VALUE;
  always_comb begin
    state_d       = state_q;
    hold_d        = hold_q;
    cycle_count_d = cycle_count_q;
    write_count_d = write_count_q;
    result_d      = result_q;
    if (abort) begin
      state_d = IDLE;
    end else if (start && (state_q == IDLE || state_q == HALTED || state_q == TIMEOUT)) begin
      state_d       = RESET_HOLD;
      hold_d        = HOLD_INIT;
      cycle_count_d = '0;
      write_count_d = '0;
      result_d      = '0;
    end else if (state_q == RESET_HOLD) begin
      state_d = hold_q == 8'd0 ? RUN : RESET_HOLD;
      hold_d  = hold_q == 8'd0 ? hold_q : hold_q - 8'd1;
    end else if (state_q == RUN) begin
      state_d       = halt ? HALTED : (&cycle_count_q ? TIMEOUT : RUN);
      write_count_d = wr_ok && ~&write_count_q ? write_count_q + 16'd1 : write_count_q;
      result_d      = wr_ok && wr.reg_writeaddr == RESULT_REG ? wr.reg_writedata : result_q;
    end
    cycle_count_d = state_d == RUN ? cycle_count_q + TIMEOUT_W'(1) : cycle_count_d;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      hold_q         <= '0;
      cycle_count_q  <= '0;
      write_count_q  <= '0;
      result_q       <= '0;
      core_reset_q   <= 1'b1;
      imem_read_en_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      timed_out_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      hold_q         <= hold_d;
      cycle_count_q  <= cycle_count_d;
      write_count_q  <= write_count_d;
      result_q       <= result_d;
      core_reset_q   <= state_d == IDLE || state_d == RESET_HOLD;
      imem_read_en_q <= state_d == RUN;
      busy_q         <= state_d == RESET_HOLD || state_d == RUN;
      done_q         <= state_d == HALTED;
      timed_out_q    <= state_d == TIMEOUT;
    end
  end
  assign core_reset   = core_reset_q;
  assign imem_read_en = imem_read_en_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign timed_out    = timed_out_q;
  assign cycle_count  = cycle_count_q;
  assign write_count  = write_count_q;
  assign result       = result_q;
endmodule

// File: tb/tb_riscv_run_controller.sv
// tb_riscv_run_controller: randomized scoreboard bench against a cycle-level reference model
module tb_riscv_run_controller;
  localparam int TW = 6;
  localparam int MAXC = 63;
  localparam int RC = 4;
  typedef struct {
    logic        cr, ie, bz, dn, to;
    logic [31:0] cyc, wc, res;
  } exp_t;
  logic clk, reset, start, abort;
  logic core_reset, imem_read_en, busy, done, timed_out;
  logic [TW-1:0] cycle_count;
  logic [15:0] write_count;
  logic [31:0] result;
  riscv_run_controller_if wr_if();
  riscv_run_controller #(.RESET_CYCLES(RC), .TIMEOUT_W(TW)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .wr(wr_if),
    .core_reset(core_reset), .imem_read_en(imem_read_en), .busy(busy), .done(done),
    .timed_out(timed_out), .cycle_count(cycle_count), .write_count(write_count), .result(result)
  );
  exp_t q[$];
  int checks = 0, errors = 0;
  bit active = 0;
  string phase = "idle";
  int left = 0, cyc = 0, wc = 0, res = 0;
  bit quiet = 0;
  int n_halt = 0, n_tmo = 0, n_async = 0;
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic exp_t expect_now();
    exp_t e;
    e.cr  = phase == "idle" || phase == "hold";
    e.ie  = phase == "run";
    e.bz  = phase == "hold" || phase == "run";
    e.dn  = phase == "halt";
    e.to  = phase == "tmo";
    e.cyc = 32'(cyc);
    e.wc  = 32'(wc);
    e.res = 32'(res);
    return e;
  endfunction
  task automatic model_step(input bit st, input bit ab, input bit v, input logic [4:0] a, input logic [31:0] d);
    if (ab) phase = "idle";
    else if (st && (phase == "idle" || phase == "halt" || phase == "tmo")) begin
      phase = "hold";
      left = RC;
      cyc = 0;
      wc = 0;
      res = 0;
    end else if (phase == "hold") begin
      left--;
      if (left == 0) begin
        phase = "run";
        cyc = 1;
      end
    end else if (phase == "run") begin
      if (v && a != 0) begin
        if (wc < 65535) wc++;
        if (a == 5'd10) res = d;
      end
      if (v && a == 5'd12 && d == 32'd1) begin
        phase = "halt";
        n_halt++;
      end else if (cyc == MAXC) begin
        phase = "tmo";
        n_tmo++;
      end else cyc++;
    end
  endtask
  task automatic rand_cycle();
    bit st, ab, v;
    logic [4:0] a;
    logic [31:0] d;
    logic [4:0] addrs [6];
    addrs = '{5'd0, 5'd5, 5'd10, 5'd12, 5'd13, 5'd0};
    addrs[5] = 5'($urandom);
    ab = $urandom_range(0, 59) == 0;
    st = (phase == "idle" || phase == "halt" || phase == "tmo") ? $urandom_range(0, 3) == 0 : $urandom_range(0, 9) == 0;
    if (st && !ab && (phase == "idle" || phase == "halt" || phase == "tmo")) quiet = $urandom_range(0, 2) == 0;
    v = $urandom_range(0, 1) == 1;
    a = addrs[$urandom_range(0, 5)];
    d = $urandom;
    if (a == 5'd12) d = quiet ? 32'd2 : ($urandom_range(0, 1) == 1 ? 32'd1 : d);
    if (phase == "run" && cyc == MAXC && $urandom_range(0, 1) == 1) begin
      v = 1;
      a = 5'd12;
      d = 32'd1;
    end
    start = st;
    abort = ab;
    wr_if.reg_wr_valid = v;
    wr_if.reg_writeaddr = a;
    wr_if.reg_writedata = d;
    model_step(st, ab, v, a, d);
    q.push_back(expect_now());
  endtask
  task automatic async_reset_cycle();
    start = 0;
    abort = 0;
    wr_if.reg_wr_valid = 0;
    reset = 0;
    #1;
    chk("async_core_reset", 32'(core_reset), 32'd1);
    chk("async_imem_read_en", 32'(imem_read_en), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    phase = "idle";
    cyc = 0;
    wc = 0;
    res = 0;
    n_async++;
    q.push_back(expect_now());
    @(negedge clk);
    reset = 1;
    rand_cycle();
  endtask
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("core_reset", 32'(core_reset), 32'(e.cr));
      chk("imem_read_en", 32'(imem_read_en), 32'(e.ie));
      chk("busy", 32'(busy), 32'(e.bz));
      chk("done", 32'(done), 32'(e.dn));
      chk("timed_out", 32'(timed_out), 32'(e.to));
      chk("cycle_count", 32'(cycle_count), e.cyc);
      chk("write_count", 32'(write_count), e.wc);
      chk("result", result, e.res);
      chk("never_both", 32'(core_reset & imem_read_en), 32'd0);
    end else if (active) chk("scoreboard_underflow", 32'(q.size()), 32'd1);
  end
  initial begin
    int budget;
    reset = 0;
    start = 0;
    abort = 0;
    wr_if.reg_wr_valid = 0;
    wr_if.reg_writeaddr = 0;
    wr_if.reg_writedata = 0;
    repeat (2) @(negedge clk);
    chk("reset_core_reset", 32'(core_reset), 32'd1);
    chk("reset_imem_read_en", 32'(imem_read_en), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_counters", 32'(cycle_count) | 32'(write_count) | result, 32'd0);
    reset = 1;
    active = 1;
    for (int i = 0; i < 12; i++) begin
      q.push_back(expect_now());
      @(negedge clk);
    end
    for (int i = 0; i < 4000; i++) begin
      if (phase == "run" && $urandom_range(0, 299) == 0) async_reset_cycle();
      else rand_cycle();
      @(negedge clk);
    end
    budget = 0;
    while (phase != "run" && budget < 500) begin
      rand_cycle();
      @(negedge clk);
      budget++;
    end
    if (phase == "run") async_reset_cycle();
    else chk("reach_run_budget", 32'(budget), 32'd0);
    @(posedge clk);
    #2;
    active = 0;
    chk("halts_seen", 32'(n_halt > 0), 32'd1);
    chk("timeouts_seen", 32'(n_tmo > 0), 32'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/riscv_run_controller.md
Name: riscv_run_controller

Overview:
Run/halt sequencer for the RISC_V_02 core. It holds the core in reset for a programmable number of cycles, then enables instruction fetch. It monitors the register-file write port for a halt marker (write of HALT_VALUE to HALT_REG) and stops the core on that marker or on a cycle timeout. The block sits between the top level or bench and the core, replacing free-running reset and imem_read_en drive, and exposes run status and counters.

Parameters:
RESET_CYCLES, 4, cycles core_reset is held high after start (1..255)
HALT_REG, 12, register address whose write with HALT_VALUE ends the run
HALT_VALUE, 32'd1, data value that marks halt
RESULT_REG, 10, register address whose last written value is captured as result
TIMEOUT_W, 20, width of cycle counter; timeout at all-ones

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset of this block
start  in  1  single-cycle pulse; begins a run from IDLE, HALTED or TIMEOUT
abort  in  1  level; forces return to IDLE from any state
reg_wr_valid  in  1  core register write strobe this cycle
reg_writeaddr  in  5  core register write address
reg_writedata  in  32  core register write data
core_reset  out  1  active-high reset to core
imem_read_en  out  1  instruction-fetch enable to core
busy  out  1  high in RESET_HOLD or RUN
done  out  1  high in HALTED
timed_out  out  1  high in TIMEOUT
cycle_count  out  TIMEOUT_W  cycles spent in RUN this run
write_count  out  16  valid writes to nonzero registers this run
result  out  32  last value written to RESULT_REG this run

Behaviour:
- Async reset (reset=0): state=IDLE; core_reset=1; imem_read_en=0; busy=done=timed_out=0; all counters and result=0. All outputs are registered.
- States: IDLE, RESET_HOLD, RUN, HALTED, TIMEOUT.
- IDLE: core_reset=1, imem_read_en=0. start -> RESET_HOLD; hold counter loads RESET_CYCLES-1; cycle_count, write_count and result clear.
- RESET_HOLD: core_reset=1, busy=1. Counter decrements each cycle. At 0 -> RUN. core_reset is high for exactly RESET_CYCLES cycles.
- RUN: core_reset=0, imem_read_en=1, busy=1. cycle_count increments every cycle.
- Writes are ignored outside RUN. A write to x0 is ignored.
- Each valid write to a nonzero register increments write_count, which saturates at 16'hFFFF.
- A valid write with reg_writeaddr==RESULT_REG updates result with reg_writedata.
- Halt: a valid write with addr==HALT_REG and data==HALT_VALUE -> HALTED next cycle. That write is counted and captured if RESULT_REG==HALT_REG.
- Timeout: cycle_count reaching all-ones with no halt -> TIMEOUT next cycle.
- If halt and timeout occur in the same cycle, halt wins.
- HALTED or TIMEOUT: imem_read_en=0, core_reset=0 so the core state stays inspectable. Counters and result freeze. done or timed_out is held until the next start or abort.
- start in HALTED or TIMEOUT -> RESET_HOLD with counters cleared. start in RESET_HOLD or RUN is ignored.
- abort, checked before start: any state -> IDLE next cycle. Counters and result are retained until the next start.
- Async reset in mid-run returns to IDLE immediately. core_reset asserts asynchronously.
- imem_read_en and core_reset are never both high.

Test Plan:
1. Reset low then high, no start -> core_reset=1, imem_read_en=0, busy=0 indefinitely; all counters 0.
2. start pulse with RESET_CYCLES=4 -> core_reset high 4 cycles, then imem_read_en=1 in the next cycle, busy=1, cycle_count counts 1,2,3…
3. In RUN, writes x10=0x2A, x5=7, x0=9, then x12=1 -> done=1 next cycle, imem_read_en=0, result=0x2A, write_count=3, cycle_count frozen.
4. TIMEOUT_W=6 with no halt write -> timed_out=1 after 63 RUN cycles, imem_read_en=0. Same-cycle halt write at count 63 -> done=1, timed_out=0.
5. Write x12=2 and x13=1 -> no halt. abort in RUN -> IDLE, core_reset=1, counters retained. start afterwards -> counters cleared and new run begins.
6. Drive reset low mid-RUN -> core_reset=1 and imem_read_en=0 asynchronously, before the next clock edge. start in HALTED -> new RESET_HOLD, done cleared.
